// File: rtl/coef_sender_pkg.sv
// Shared definitions for the coefficient sender and the matrix controller:
// default frame geometry and the sender FSM state encoding.
package coef_sender_pkg;

  localparam int CW_DEF    = 8;
  localparam int NCOEF_DEF = 12;
  localparam int LEAD_DEF  = 3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_LEAD = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } sender_state_t;

endpackage

// File: rtl/coef_sender_buf.sv
// Coefficient register buffer: one write port and one indexed read port.
// Out-of-range write addresses are dropped; out-of-range reads return zero.
module coef_buf #(
  parameter int CW    = 8,
  parameter int NCOEF = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr_en,
  input  logic [3:0]    i_wr_addr,
  input  logic [CW-1:0] i_wr_data,
  input  logic [3:0]    i_rd_addr,
  output logic [CW-1:0] o_rd_data
);

  localparam logic [3:0] LAST_IDX = 4'(NCOEF - 1);

  logic [CW-1:0] r_mem [NCOEF];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCOEF; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en && (i_wr_addr <= LAST_IDX)) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = (i_rd_addr <= LAST_IDX) ? r_mem[i_rd_addr] : '0;

endmodule

// File: rtl/coef_sender.sv
// Streams a buffered frame of NCOEF coefficients to the matrix controller:
// a cf_load pulse, LEAD-1 quiet cycles, then one coefficient per cycle.
module coef_sender
  import coef_sender_pkg::*;
#(
  parameter int CW    = CW_DEF,
  parameter int NCOEF = NCOEF_DEF,
  parameter int LEAD  = LEAD_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [3:0]    wr_addr,
  input  logic [CW-1:0] wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          cf_load,
  output logic          cf_valid,
  output logic [CW-1:0] cf_data,
  output logic [3:0]    cf_idx
);

  localparam logic [3:0] LAST_IDX  = 4'(NCOEF - 1);
  localparam logic [3:0] LEAD_LAST = 4'((LEAD > 1) ? (LEAD - 2) : 0);

  sender_state_t r_state;
  sender_state_t w_next;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_next;
  logic [CW-1:0] w_rd_data;
  logic          w_wr_en;

  // Writes are only accepted while no frame is in flight, so a frame is never torn.
  assign w_wr_en = wr_en && !busy;

  coef_buf #(
    .CW    (CW),
    .NCOEF (NCOEF)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_addr (r_cnt),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // r_cnt counts quiet cycles in LEAD, then doubles as the read index in SEND.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    busy       = 1'b0;
    done       = 1'b0;
    cf_load    = 1'b0;
    cf_valid   = 1'b0;
    cf_data    = '0;
    cf_idx     = '0;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        if (start) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        busy       = 1'b1;
        cf_load    = 1'b1;
        w_cnt_next = '0;
        w_next     = (LEAD > 1) ? S_LEAD : S_SEND;
      end
      S_LEAD: begin
        busy = 1'b1;
        if (r_cnt == LEAD_LAST) begin
          w_next     = S_SEND;
          w_cnt_next = '0;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      S_SEND: begin
        busy     = 1'b1;
        cf_valid = 1'b1;
        cf_idx   = r_cnt;
        cf_data  = w_rd_data;
        if (r_cnt == LAST_IDX) begin
          w_next     = S_DONE;
          w_cnt_next = '0;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next     = S_IDLE;
        w_cnt_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_coef_sender.sv
// Directed bench for coef_sender: frame timing, write gating, retention,
// start collisions and mid-frame reset, with hand-computed expectations.
module tb_coef_sender;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic       busy;
  logic       done;
  logic       cf_load;
  logic       cf_valid;
  logic [7:0] cf_data;
  logic [3:0] cf_idx;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] expData [12];

  coef_sender dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .cf_load  (cf_load),
    .cf_valid (cf_valid),
    .cf_data  (cf_data),
    .cf_idx   (cf_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector layout: {busy, done, cf_load, cf_valid, cf_idx, cf_data}
  task automatic checkOutput(input string tag, input logic [15:0] expected);
    logic [15:0] observed;
    observed = {busy, done, cf_load, cf_valid, cf_idx, cf_data};
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] addr, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Caller raises start in cycle T; this checks T+1 .. T+17 and returns in
  // the idle cycle after done, where the caller may raise start again.
  task automatic runFrame(input bit poke);
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    checkOutput("load", {4'b1010, 4'd0, 8'd0});
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("lead", {4'b1000, 4'd0, 8'd0});
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checkOutput("send", {4'b1001, 4'(k), expData[k]});
      if (poke && k == 1) begin
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 4'd2;
        wr_data = 8'h77;
      end else if (poke && k == 2) begin
        start = 1'b0;
        wr_en = 1'b0;
      end
    end
    @(negedge clk);
    checkOutput("done", {4'b0100, 4'd0, 8'd0});
    @(negedge clk);
    checkOutput("idle_after_done", 16'h0000);
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = 4'd0;
    wr_data = 8'd0;
    start   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset", 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle", 16'h0000);

    for (int k = 0; k < 12; k++) begin
      applyStimulus(4'(k), 8'(k + 1));
      expData[k] = 8'(k + 1);
    end
    applyStimulus(4'd12, 8'hFF);
    applyStimulus(4'd15, 8'hEE);
    checkOutput("idle_after_writes", 16'h0000);

    $display("[TB] basic frame");
    start = 1'b1;
    runFrame(1'b0);

    $display("[TB] start and write during busy, then chained frame");
    start = 1'b1;
    runFrame(1'b1);
    start = 1'b1;
    runFrame(1'b0);

    $display("[TB] write and start in the same cycle");
    wr_en   = 1'b1;
    wr_addr = 4'd0;
    wr_data = 8'hA5;
    start   = 1'b1;
    expData[0] = 8'hA5;
    runFrame(1'b0);

    $display("[TB] reset in the middle of SEND");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("send_idx5", {4'b1001, 4'd5, 8'd6});
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("after_reset", 16'h0000);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkOutput("aborted_quiet", 16'h0000);
    end

    for (int k = 0; k < 12; k++) begin
      expData[k] = 8'd0;
    end
    start = 1'b1;
    runFrame(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
